vga_timing_gen: RTL and testbench

Parametrised VGA timing generator. It is the successor to the fixed 640x480 sync block in the pong top level.
- Derives the pixel tick from the system clock with a programmable divider.
- Produces pixel coordinates, blanking, sync, line and frame strobes.
- Provides a configurable sync/blank delay line, so the PGC rgb register (or deeper pixel pipelines) stays aligned with h_sync/v_sync without glue logic in top_level.

---
 rtl/vga_timing_gen_pkg.sv | 31 +++
 rtl/sync_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, sync polarity names and the total-count helper
// used by the vga_timing_gen block (package vga_pkg).
package vga_pkg;

  // 640x480@60 with a 25 MHz pixel clock.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Bits carried through the sync/blank delay line, asserted-high internally.
  typedef struct packed {
    logic h;
    logic v;
    logic video;
  } sync_bits_t;

  // Works for either axis: H_TOTAL and V_TOTAL are both active+front+sync+back.
  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parametrised shift register that keeps sync/blank aligned with a pixel
// pipeline; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] d_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, reset};
    assign d_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, so sync reads deasserted until real data
    // has shifted through; a non-reset pipe would emit X/garbage sync pulses.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign d_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters, strobes
// and a delayed sync/blank path. Define VGA_FRAME_COUNT_EN for the frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FRONT    = H_FRONT_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BACK     = H_BACK_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FRONT    = V_FRONT_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BACK     = V_BACK_DEF,
  parameter int   CLK_DIV    = 4,
  parameter logic SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int   PIPE_DELAY = 1,
  parameter int   CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          p_tick,
  output logic          video_on,
  output logic          video_on_d,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic          p_tick_q, p_tick_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          tick, h_wrap, v_wrap;
  sync_bits_t    raw, raw_dly;

  // A tick raised just before enable drops is held and delivered on re-enable,
  // so freezing never skips or duplicates a pixel.
  assign tick   = p_tick_q & enable;
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    div_d    = div_q;
    p_tick_d = p_tick_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (enable) begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      p_tick_d = (div_q == DIV_LAST);
    end
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      p_tick_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
    end else begin
      div_q    <= div_d;
      p_tick_q <= p_tick_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
    end
  end

  assign raw.h     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign raw.v     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign raw.video = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(3'b000)
  ) u_sync_delay (
    .clk  (clk),
    .reset(reset),
    .d_i  (raw),
    .d_o  (raw_dly)
  );

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign p_tick      = tick;
  assign video_on    = raw.video;
  assign video_on_d  = raw_dly.video;
  assign h_sync      = raw_dly.h ? SYNC_POL : ~SYNC_POL;
  assign v_sync      = raw_dly.v ? SYNC_POL : ~SYNC_POL;
  assign line_start  = tick & h_wrap;
  assign frame_start = line_start & v_wrap;

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an
// arithmetic position model, plus directed sync/freeze/reset expectations.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CW    = 10;
  localparam int N_DUT = 3;
`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  typedef struct {
    int   ha, hf, hs, hb, va, vf, vs, vb, div, pd;
    logic pol;
  } cfg_t;

  // 0: default horizontal, short frame; 1: tiny CLK_DIV=1; 2: as 0 with PD=3, active-high sync
  function automatic cfg_t get_cfg(input int d);
    cfg_t c;
    c = '{ha:640, hf:16, hs:96, hb:48, va:4, vf:1, vs:2, vb:1, div:4, pd:1, pol:1'b0};
    if (d == 1) c = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1, div:1, pd:1, pol:1'b0};
    if (d == 2) begin
      c.pd  = 3;
      c.pol = 1'b1;
    end
    return c;
  endfunction

  logic clk = 1'b0;
  logic reset, enable;
  always #5 clk = ~clk;

  logic [CW-1:0] px [N_DUT];
  logic [CW-1:0] py [N_DUT];
  logic [7:0]    fc [N_DUT];
  logic pt [N_DUT], vo [N_DUT], vod [N_DUT], hs [N_DUT], vs [N_DUT], ls [N_DUT], fs [N_DUT];
  logic [34:0]   act [N_DUT];

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(4), .SYNC_POL(SYNC_ACTIVE_LOW), .PIPE_DELAY(1), .CW(CW)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pixel_x(px[0]), .pixel_y(py[0]),
    .p_tick(pt[0]), .video_on(vo[0]), .video_on_d(vod[0]), .h_sync(hs[0]), .v_sync(vs[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .frame_cnt(fc[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .SYNC_POL(SYNC_ACTIVE_LOW), .PIPE_DELAY(1), .CW(CW)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pixel_x(px[1]), .pixel_y(py[1]),
    .p_tick(pt[1]), .video_on(vo[1]), .video_on_d(vod[1]), .h_sync(hs[1]), .v_sync(vs[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .frame_cnt(fc[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(4), .SYNC_POL(SYNC_ACTIVE_HIGH), .PIPE_DELAY(3), .CW(CW)
  ) u_dut_c (
    .clk(clk), .reset(reset), .enable(enable), .pixel_x(px[2]), .pixel_y(py[2]),
    .p_tick(pt[2]), .video_on(vo[2]), .video_on_d(vod[2]), .h_sync(hs[2]), .v_sync(vs[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .frame_cnt(fc[2])
  );

  for (genvar d = 0; d < N_DUT; d++) begin : g_pack
    assign act[d] = {px[d], py[d], pt[d], vo[d], vod[d], hs[d], vs[d], ls[d], fs[d], fc[d]};
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
      if (n_err >= 50) begin
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
      end
    end
  endtask

  // ---------------- model: position is a pure function of enabled edges ----------------
  function automatic int ht_of(input cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
  function automatic int vt_of(input cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction

  // A tick is raised every div enabled edges and consumed on the next enabled edge.
  function automatic int pos_at(input cfg_t c, input int kk);
    int consumed;
    consumed = (kk == 0) ? 0 : (kk - 1) / c.div;
    return consumed % (ht_of(c) * vt_of(c));
  endfunction

  function automatic logic [2:0] raw_at(input cfg_t c, input int kk);
    int h, v;
    h = pos_at(c, kk) % ht_of(c);
    v = pos_at(c, kk) / ht_of(c);
    return {(h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs),
            (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs),
            (h < c.ha) && (v < c.va)};
  endfunction

  function automatic logic [34:0] exp_out(input cfg_t c, input int kk, input logic en,
                                          input logic [2:0] dly, input logic [7:0] fcm);
    int h, v;
    logic p, l, f;
    logic [2:0] r, dd;
    h  = pos_at(c, kk) % ht_of(c);
    v  = pos_at(c, kk) / ht_of(c);
    p  = (kk > 0) && (kk % c.div == 0) && en;
    l  = p && (h == ht_of(c) - 1);
    f  = l && (v == vt_of(c) - 1);
    r  = raw_at(c, kk);
    dd = (c.pd == 0) ? r : dly;
    return {CW'(h), CW'(v), p, r[0], dd[0], dd[2] ? c.pol : ~c.pol,
            dd[1] ? c.pol : ~c.pol, l, f, fcm};
  endfunction

  int         k    [N_DUT];
  logic [2:0] hist [N_DUT][4];
  logic [7:0] fc_m [N_DUT];
  bit         chk_on     = 1'b0;
  bit         reset_edge = 1'b0;

  always @(posedge clk) begin
    cfg_t       c;
    logic [34:0] e;
    for (int d = 0; d < N_DUT; d++) begin
      c = get_cfg(d);
      if (reset) begin
        k[d]    = 0;
        fc_m[d] = 8'd0;
        for (int i = 1; i < 4; i++) hist[d][i] = 3'b000;
      end else begin
        e = exp_out(c, k[d], enable, hist[d][c.pd], fc_m[d]);
        if (FC_EN && e[8]) fc_m[d] = fc_m[d] + 8'd1;
        for (int i = 3; i >= 2; i--) hist[d][i] = hist[d][i-1];
        hist[d][1] = raw_at(c, k[d]);
        if (enable) k[d] = k[d] + 1;
      end
    end
    reset_edge = reset;
    if (reset) chk_on = 1'b1;
  end

  // Compare every DUT output against the model on every cycle after reset.
  always @(negedge clk) begin
    cfg_t c;
    if (chk_on) begin
      for (int d = 0; d < N_DUT; d++) begin
        c = get_cfg(d);
        check($sformatf("dut%0d_outputs", d), 64'(act[d]),
              64'(exp_out(c, k[d], enable, hist[d][c.pd], fc_m[d])));
      end
    end
  end

  // ---------------- directed literal expectations ----------------
  int a_line_ticks = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      if (reset_edge) a_line_ticks = 0;
      else if (pt[0]) begin
        a_line_ticks++;
        if (ls[0]) begin
          check("a_line_ticks", 64'(a_line_ticks), 64'd800);
          a_line_ticks = 0;
        end
      end
    end
  end

  bit   phase2 = 1'b0;
  int   cyc = 0, hs_run = 0, vs_run = 0, a_vid = 0, b_fs_n = 0;
  int   a_fs_last = -1, b_ls_last = -1, b_fs_last = -1, c_656_at = -1000;
  bit   hs_run_ok = 1'b0, vs_run_ok = 1'b0, b_fs_prev = 1'b0;
  logic hs0_p = 1'b1, vs0_p = 1'b1, hs2_p = 1'b0;
  logic [CW-1:0] px2_p = '0;

  always @(negedge clk) begin
    cyc++;
    if (phase2) begin
      if (hs0_p && !hs[0]) begin
        check("a_hsync_start_x", 64'(px[0]), 64'd656);
        hs_run = 0; hs_run_ok = 1'b1;
      end
      if (!hs[0]) hs_run++;
      if (!hs0_p && hs[0] && hs_run_ok) check("a_hsync_low_clk", 64'(hs_run), 64'd384);
      if (vs0_p && !vs[0]) begin
        check("a_vsync_start_y", 64'(py[0]), 64'd5);
        check("a_vsync_start_x", 64'(px[0]), 64'd0);
        vs_run = 0; vs_run_ok = 1'b1;
      end
      if (!vs[0]) vs_run++;
      if (!vs0_p && vs[0] && vs_run_ok) check("a_vsync_low_clk", 64'(vs_run), 64'd6400);
      if (pt[0] && vo[0]) a_vid++;
      if (fs[0]) begin
        check("a_video_ticks", 64'(a_vid), 64'd2560);
        a_vid = 0;
        if (a_fs_last >= 0) check("a_frame_period_clk", 64'(cyc - a_fs_last), 64'd25600);
        a_fs_last = cyc;
      end
      if (ls[1]) begin
        if (b_ls_last >= 0) check("b_line_period_clk", 64'(cyc - b_ls_last), 64'd14);
        b_ls_last = cyc;
      end
      if (fs[1]) begin
        if (b_fs_last >= 0) check("b_frame_period_clk", 64'(cyc - b_fs_last), 64'd98);
        b_fs_last = cyc;
      end
      if (b_fs_prev && (b_fs_n == 3 || b_fs_n == 255 || b_fs_n == 256))
        check($sformatf("b_frame_cnt_after_%0d", b_fs_n), 64'(fc[1]),
              FC_EN ? 64'(b_fs_n % 256) : 64'd0);
      b_fs_prev = fs[1];
      if (fs[1]) b_fs_n++;
      if (px[2] == 10'd656 && px2_p != 10'd656) c_656_at = cyc;
      if (hs[2] && !hs2_p) check("c_hsync_rise_delay", 64'(cyc - c_656_at), 64'd3);
    end
    hs0_p = hs[0]; vs0_p = vs[0]; hs2_p = hs[2]; px2_p = px[2];
  end

  // ---------------- stimulus ----------------
  bit found;
  int n;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    phase2 = 1'b1;
    repeat (2 * 25600 + 20) @(posedge clk);
    #2 phase2 = 1'b0;

    // Freeze at pixel_x=100, two clk into the tick.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (pt[0] && px[0] == 10'd99) found = 1'b1;
    end
    check("freeze_reach_x99", 64'(found), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2 enable = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("freeze_x_hold", 64'(px[0]), 64'd100);
      check("freeze_no_tick", 64'(pt[0]), 64'd0);
    end
    @(posedge clk);
    #2 enable = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pt[0]) found = 1'b1;
    end
    check("resume_tick_edges", 64'(n), 64'd2);
    check("resume_x_still_100", 64'(px[0]), 64'd100);

    // Mid-frame reset at pixel (300,3).
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      @(negedge clk);
      if (px[0] == 10'd300 && py[0] == 10'd3) found = 1'b1;
    end
    check("reset_reach_300_3", 64'(found), 64'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_x", 64'(px[0]), 64'd0);
    check("reset_y", 64'(py[0]), 64'd0);
    check("reset_hsync", 64'(hs[0]), 64'd1);
    check("reset_vsync", 64'(vs[0]), 64'd1);
    check("reset_ptick", 64'(pt[0]), 64'd0);
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pt[0]) found = 1'b1;
    end
    check("reset_first_tick_edges", 64'(n), 64'd4);

    repeat (4000) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
